ysyx_24100005_ifu: RTL and testbench
====================================

YSYX_24100005_IFU -- requirements
Module: ysyx_24100005_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port arvalid, output, 1 bit: instruction-memory read request valid.
REQ-005 SHALL have port arready, input, 1 bit: memory accepts the request.
REQ-006 SHALL have port araddr, output, 32 bits: fetch address, equal to pc.
REQ-007 SHALL have port rvalid, input, 1 bit: read data valid.
REQ-008 SHALL have port rready, output, 1 bit: IFU accepts read data.
REQ-009 SHALL have port rdata, input, 32 bits: fetched instruction word.
REQ-010 SHALL have port rresp, input, 2 bits: read response, where 2'b00 means OK.
REQ-011 SHALL have port inst_valid, output, 1 bit: inst/pc valid toward the core.
REQ-012 SHALL have port inst_ready, input, 1 bit: core consumes the instruction.
REQ-013 SHALL have port inst, output, 32 bits: instruction to the core.
REQ-014 SHALL have port pc, output, 32 bits: address of inst and of the current fetch.
REQ-015 SHALL have port dnpc_valid, input, 1 bit: core presents the next PC.
REQ-016 SHALL have port dnpc, input, 32 bits: next PC from the core.
REQ-017 SHALL have port fetch_err, output, 1 bit: sticky fetch fault.
REQ-018 SHALL have port fetch_cnt, output, 32 bits: count of delivered instructions.

Function
REQ-019 SHALL implement the states IDLE, AR, R, OUT, WPC and ERR, with outputs decoded from the registered state only.
REQ-020 SHALL make the output decode as follows: arvalid=1 only in AR; rready=1 only in R; inst_valid=1 only in OUT; fetch_err=1 only in ERR.
REQ-021 SHALL transition IDLE->AR unconditionally one cycle after reset release.
REQ-022 SHALL, in AR, hold araddr=pc stable, and move to R on arvalid&arready.
REQ-023 SHALL, in R, on rvalid with rresp==2'b00, latch rdata into inst and move to OUT.
REQ-024 SHALL, in R, on rvalid with rresp!=2'b00, leave inst unchanged and move to ERR.
REQ-025 SHALL, in OUT, hold inst and pc stable until inst_ready.
REQ-026 SHALL, on the OUT handshake (inst_valid&inst_ready), increment fetch_cnt by 1, with modulo-2^32 wrap.
REQ-027 SHALL, on the OUT handshake with dnpc_valid high in the same cycle, take dnpc directly (WPC skipped).
REQ-028 SHALL, on the OUT handshake with dnpc_valid low, move to WPC.
REQ-029 SHALL, in WPC, wait for dnpc_valid, then take dnpc.
REQ-030 SHALL, when taking dnpc, load pc<=dnpc, then go to AR if dnpc[1:0]==2'b00, else go to ERR; pc in ERR shows the faulting address.
REQ-031 SHALL ignore dnpc_valid in IDLE, AR, R and ERR, and in OUT when inst_ready is low.
REQ-032 SHALL make ERR terminal: all handshake outputs 0, fetch_err=1, pc/inst/fetch_cnt frozen, exit only by reset.
REQ-033 SHALL never have more than one memory request outstanding, and SHALL issue no new request before the core supplies dnpc.
REQ-034 SHALL tolerate back-to-back single-cycle handshakes, giving a best case of 3 cycles per instruction (AR, R, OUT).

Reset
REQ-035 SHALL, while rst=0, immediately force state=IDLE, pc=RESET_PC, inst=0, fetch_cnt=0, arvalid=0, rready=0, inst_valid=0 and fetch_err=0.
REQ-036 SHALL, on a reset asserted mid-transaction (AR/R/OUT/WPC), abandon that transaction with no further effect; a late rvalid arriving after reset SHALL be ignored because rready=0 outside R.

Verification
REQ-037 SHALL verify basic fetch: release reset, memory returns 32'h00000413 at 0x80000000 with arready=rvalid=1 and inst_ready=1, dnpc=0x80000004 same cycle -> inst_valid on 3rd cycle after IDLE, inst=0x00000413, next araddr=0x80000004, fetch_cnt=1.
REQ-038 SHALL verify stalls: arready low for 4 cycles, rvalid delayed 3 cycles, inst_ready delayed 2 cycles -> araddr/inst/pc stable throughout, exactly one request issued, fetch_cnt increments once.
REQ-039 SHALL verify the WPC path: inst_ready=1 with dnpc_valid=0, then dnpc_valid=1, dnpc=0x80000100 two cycles later -> state waits in WPC, then arvalid=1 with araddr=0x80000100.
REQ-040 SHALL verify faults: rresp=2'b10 -> fetch_err=1 next cycle and sticky; dnpc=0x80000102 -> fetch_err=1, pc=0x80000102, arvalid stays 0.
REQ-041 SHALL verify async reset: rst low mid-R with rvalid pulsing -> outputs reset without a clock edge; after release, refetch from 0x80000000 with fetch_cnt=0.
REQ-042 SHALL verify counter wrap: fetch_cnt preloaded via force to 32'hFFFF_FFFF, one delivered instruction -> fetch_cnt=0.

Source files
------------

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one read per instruction, handed to the core with its pc, then waits for dnpc.
// Best case 3 cycles/instruction (AR, R, OUT); every handshake may stall; faults park in ERR until reset.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        dnpc_valid,
  input  logic [31:0] dnpc,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {IDLE, AR, R, OUT, WPC, ERR} state_t;

  state_t state;
  state_t state_nxt;
  logic   deliver;
  logic   take_pc;
  logic   read_ok;

  assign deliver = (state == OUT) && inst_ready;
  // dnpc is only meaningful on the delivery handshake or while parked in WPC
  assign take_pc = (deliver || (state == WPC)) && dnpc_valid;
  assign read_ok = (state == R) && rvalid && (rresp == 2'b00);
  assign araddr  = pc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = AR;
      AR:      if (arready) state_nxt = R;
      R:       if (rvalid) state_nxt = (rresp == 2'b00) ? OUT : ERR;
      OUT:     if (inst_ready) state_nxt = WPC;
      default: state_nxt = state;
    endcase
    if (take_pc) state_nxt = (dnpc[1:0] == 2'b00) ? AR : ERR;
  end

  // Handshake outputs are flopped from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      fetch_cnt  <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      arvalid    <= (state_nxt == AR);
      rready     <= (state_nxt == R);
      inst_valid <= (state_nxt == OUT);
      fetch_err  <= (state_nxt == ERR);
      if (read_ok) inst <= rdata;
      if (deliver) fetch_cnt <= fetch_cnt + 32'd1;
      if (take_pc) pc <= dnpc;
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Bench for ysyx_24100005_ifu: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ysyx_24100005_ifu;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arready = 1'b0, rvalid = 1'b0, inst_ready = 1'b0, dnpc_valid = 1'b0;
  logic [1:0]  rresp = 2'b00;
  logic [31:0] rdata = '0, dnpc = '0;
  logic        arvalid, rready, inst_valid, fetch_err;
  logic [31:0] araddr, inst, pc, fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int ar_hs    = 0;

  ysyx_24100005_ifu #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .dnpc_valid(dnpc_valid), .dnpc(dnpc),
    .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Memory contents: word at 0x80000000 is 0x00000413
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ RPC) * 32'h9E37_79B1 + 32'h0000_0413;
  endfunction

  // What the IFU is doing, at transaction level
  typedef enum {P_IDLE, P_ADDR, P_DATA, P_DELIV, P_WPC, P_FAULT} phase_t;
  phase_t      m_phase = P_IDLE;
  logic [31:0] m_pc    = RPC;
  logic [31:0] m_inst  = '0;
  logic [31:0] m_cnt   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic take_dnpc();
    m_pc    = dnpc;
    m_phase = (dnpc % 4 == 0) ? P_ADDR : P_FAULT;
  endtask

  // Model: advance on each clock edge from the inputs presented, reset asynchronously
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_phase = P_IDLE; m_pc = RPC; m_inst = '0; m_cnt = '0;
    end else begin
      case (m_phase)
        P_IDLE:  m_phase = P_ADDR;
        P_ADDR:  if (arready) m_phase = P_DATA;
        P_DATA:  if (rvalid) begin
                   if (rresp == 2'b00) begin m_inst = mem_word(m_pc); m_phase = P_DELIV; end
                   else m_phase = P_FAULT;
                 end
        P_DELIV: if (inst_ready) begin
                   m_cnt = m_cnt + 32'd1;
                   if (dnpc_valid) take_dnpc(); else m_phase = P_WPC;
                 end
        P_WPC:   if (dnpc_valid) take_dnpc();
        default: ;
      endcase
    end
  end

  // Compare every cycle, mid-period
  initial forever begin
    @(negedge clk);
    chk("arvalid",    32'(arvalid),    32'(m_phase == P_ADDR));
    chk("rready",     32'(rready),     32'(m_phase == P_DATA));
    chk("inst_valid", 32'(inst_valid), 32'(m_phase == P_DELIV));
    chk("fetch_err",  32'(fetch_err),  32'(m_phase == P_FAULT));
    chk("araddr",     araddr,          m_pc);
    chk("pc",         pc,              m_pc);
    chk("inst",       inst,            m_inst);
    chk("fetch_cnt",  fetch_cnt,       m_cnt);
  end

  // One clock; counts the AR handshake about to happen and plays the memory's data bus
  task automatic cyc();
    if (arvalid && arready) ar_hs++;
    rdata = (m_phase == P_DATA && rvalid) ? mem_word(m_pc) : $urandom();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int fault_cycles = 0;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);

    // Basic fetch, all handshakes immediate
    #2 rst = 1'b1;
    arready = 1; rvalid = 1; rresp = 2'b00; inst_ready = 1; dnpc_valid = 1; dnpc = RPC + 32'd4;
    cyc(); chk("basic_ar", 32'(arvalid), 32'd1); chk("basic_araddr", araddr, RPC);
    cyc(); chk("basic_r", 32'(rready), 32'd1);
    cyc(); chk("basic_out", 32'(inst_valid), 32'd1); chk("basic_inst", inst, 32'h0000_0413);
    chk("basic_pc", pc, RPC);
    cyc(); chk("basic_next_araddr", araddr, RPC + 32'd4); chk("basic_cnt", fetch_cnt, 32'd1);

    // Stalls on every handshake
    arready = 0; rvalid = 0; inst_ready = 0; dnpc_valid = 0; ar_hs = 0;
    repeat (4) begin
      cyc(); chk("stall_arvalid", 32'(arvalid), 32'd1); chk("stall_araddr", araddr, RPC + 32'd4);
    end
    arready = 1; cyc(); arready = 0;
    repeat (3) begin
      cyc(); chk("stall_rready", 32'(rready), 32'd1); chk("stall_r_araddr", araddr, RPC + 32'd4);
    end
    rvalid = 1; cyc(); rvalid = 0;
    repeat (2) begin
      cyc(); chk("stall_out", 32'(inst_valid), 32'd1); chk("stall_inst", inst, 32'h78DD_EAD7);
      chk("stall_pc", pc, RPC + 32'd4);
    end
    inst_ready = 1; dnpc_valid = 1; dnpc = RPC + 32'd8;
    cyc(); inst_ready = 0; dnpc_valid = 0;
    chk("stall_cnt", fetch_cnt, 32'd2); chk("stall_one_req", 32'(ar_hs), 32'd1);
    chk("stall_next_araddr", araddr, RPC + 32'd8);

    // WPC path
    arready = 1; cyc(); arready = 0;
    rvalid = 1; cyc(); rvalid = 0;
    chk("wpc_out_inst", inst, 32'hF1BB_D19B);
    inst_ready = 1; cyc(); inst_ready = 0;
    chk("wpc_no_ar", 32'(arvalid), 32'd0); chk("wpc_no_out", 32'(inst_valid), 32'd0);
    cyc(); chk("wpc_still_wait", 32'(arvalid), 32'd0);
    dnpc_valid = 1; dnpc = RPC + 32'h100; cyc(); dnpc_valid = 0;
    chk("wpc_ar", 32'(arvalid), 32'd1); chk("wpc_araddr", araddr, RPC + 32'h100);
    chk("wpc_cnt", fetch_cnt, 32'd3);

    // Error response is terminal
    arready = 1; cyc(); arready = 0;
    rvalid = 1; rresp = 2'b10; cyc(); rvalid = 0; rresp = 2'b00;
    chk("rresp_err", 32'(fetch_err), 32'd1); chk("rresp_no_out", 32'(inst_valid), 32'd0);
    repeat (5) begin
      arready = 1'($urandom); rvalid = 1'($urandom); inst_ready = 1'($urandom);
      dnpc_valid = 1'($urandom); dnpc = $urandom();
      cyc();
      chk("err_sticky", 32'(fetch_err), 32'd1); chk("err_arvalid", 32'(arvalid), 32'd0);
      chk("err_pc", pc, RPC + 32'h100); chk("err_inst", inst, 32'hF1BB_D19B);
      chk("err_cnt", fetch_cnt, 32'd3);
    end

    // Misaligned dnpc
    do_reset();
    arready = 1; rvalid = 1; rresp = 2'b00; inst_ready = 1; dnpc_valid = 1; dnpc = 32'h8000_0102;
    repeat (4) cyc();
    chk("mis_err", 32'(fetch_err), 32'd1); chk("mis_pc", pc, 32'h8000_0102);
    chk("mis_cnt", fetch_cnt, 32'd1);
    repeat (3) begin cyc(); chk("mis_no_ar", 32'(arvalid), 32'd0); end

    // Asynchronous reset in the middle of a read
    do_reset();
    dnpc = RPC + 32'd4;
    repeat (4) cyc();
    rvalid = 0; cyc(); arready = 0;
    chk("ar_mid_r", 32'(rready), 32'd1); chk("ar_mid_cnt", fetch_cnt, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rready", 32'(rready), 32'd0); chk("async_arvalid", 32'(arvalid), 32'd0);
    chk("async_pc", pc, RPC); chk("async_inst", inst, 32'd0); chk("async_cnt", fetch_cnt, 32'd0);
    rvalid = 1; cyc(); rvalid = 0; cyc();
    #2 rst = 1'b1; rvalid = 1;
    cyc(); chk("refetch_ar", 32'(arvalid), 32'd1); chk("refetch_addr", araddr, RPC);
    chk("refetch_cnt", fetch_cnt, 32'd0);
    cyc(); chk("late_rvalid_ignored", 32'(rready), 32'd0);
    rvalid = 0;

    // Counter wrap
    arready = 1; cyc(); arready = 0;
    rvalid = 1; cyc(); rvalid = 0; inst_ready = 0;
    #2 force dut.fetch_cnt = 32'hFFFF_FFFF; m_cnt = 32'hFFFF_FFFF;
    cyc();
    #2 release dut.fetch_cnt;
    chk("wrap_preload", fetch_cnt, 32'hFFFF_FFFF);
    inst_ready = 1; dnpc_valid = 1; dnpc = RPC + 32'd4;
    cyc(); chk("wrap_cnt", fetch_cnt, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arready    = ($urandom_range(0, 3) != 0);
      rvalid     = ($urandom_range(0, 2) == 0);
      rresp      = ($urandom_range(0, 40) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      inst_ready = ($urandom_range(0, 2) != 0);
      dnpc_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 19))
        0:       dnpc = $urandom();
        1, 2:    dnpc = $urandom() & 32'hFFFF_FFFC;
        default: dnpc = m_pc + 32'd4;
      endcase
      if (m_phase == P_FAULT) fault_cycles++;
      if (fault_cycles > 4 || $urandom_range(0, 299) == 0) begin
        fault_cycles = 0;
        do_reset();
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
